oam_dma_controller: RTL and testbench
=====================================

// Module: oam_dma_controller
// PURPOSE
//  Owns the shared GB bus (A/Do/Di/wr_n/rd_n/cs_n) between the CPU and the OAM DMA engine.
//  A CPU write to DMA register FF46 copies LENGTH bytes from {src_hi,00} to DEST_BASE.
//  While the copy runs, the block locks the CPU out of the bus. It sits between the CPU
//  bus port and the WRAM/ROM/OAM decode.
// PARAMETERS
//  LENGTH     160       bytes per transfer (1..256)
//  DEST_BASE  16'hFE00  OAM base; dest = DEST_BASE + idx
//  REG_ADDR   16'hFF46  DMA source register address
// PORTS
//  clock      in   1   core clock; all state on posedge
//  reset_n    in   1   synchronous, active-low reset
//  tick       in   1   1-cycle strobe at M-cycle rate; DMA advances only on tick
//  cpu_A      in   16  CPU address
//  cpu_Do     in   8   CPU write data
//  cpu_Di     out  8   CPU read data
//  cpu_wr_n   in   1   CPU write strobe, active low
//  cpu_rd_n   in   1   CPU read strobe, active low
//  cpu_cs_n   in   1   CPU chip select, active low
//  A          out  16  bus address
//  Do         out  8   bus write data
//  Di         in   8   bus read data
//  wr_n       out  1   bus write strobe, active low
//  rd_n       out  1   bus read strobe, active low
//  cs_n       out  1   bus chip select, active low
//  dma_active out  1   high in START/READ/WRITE
// BEHAVIOUR
//  Reset (reset_n=0 at posedge): state IDLE, idx=0, data_q=0, src_hi=8'hFF, dma_active=0.
//   Bus is released on the next cycle. Reset mid-transfer abandons the transfer;
//   bytes already written stay in OAM.
//  reg_hit = !cpu_cs_n && cpu_A==REG_ADDR. A reg write is captured on the first clock of
//   an asserted cpu_wr_n (edge-detect: wr_q). Held strobes do not retrigger.
//  reg_hit never reaches the bus: cs_n stays 1 for that access. A read returns src_hi.
//  Writes to REG_ADDR are accepted in every state.
//   A write while active restarts: idx=0, new src_hi, state START.
//   A restart beats a coincident tick; the in-flight byte is dropped.
//  FSM (transitions on posedge with tick=1, except the register write):
//   IDLE  --reg write--> START
//   START --tick--> READ      (1 M-cycle setup; bus idle, cs_n=1)
//   READ  --tick--> WRITE     (data_q<=Di)
//   WRITE --tick--> READ  idx<=idx+1, if idx!=LENGTH-1
//   WRITE --tick--> IDLE  idx<=0,     if idx==LENGTH-1
//  READ drive:  A={src_eff,idx[7:0]}, rd_n=0, wr_n=1, cs_n=0.
//  WRITE drive: A=DEST_BASE+idx, Do=data_q, wr_n=0, rd_n=1, cs_n=0.
//  src_eff = (src_hi>=8'hE0) ? src_hi & 8'hDF : src_hi   (echo -> WRAM).
//  Latency: a write at tick-aligned cycle N gives dma_active=1 from N+1.
//   Last byte write is at tick 2*LENGTH+1 (321 for 160). dma_active=0 the cycle after.
//  CPU lockout (dma_active=1, non-reg access): bus not driven by CPU; writes dropped;
//   reads return 8'hFF. HRAM/IE (>=FF80) are decoded upstream and never arrive here.
//  Idle pass-through: A/Do/wr_n/rd_n/cs_n = cpu_* combinationally; cpu_Di=Di.
//  Bus outputs are combinational from state/idx/data_q/cpu_*. No extra latency.
//  idx is 8 bits; DEST_BASE+idx computed at 16 bits with no wrap.
// STRUCTURE
//  Shared package gb_defs.vh: REG_DMA (16'hFF46), OAM_BASE (16'hFE00), OAM_LEN (160),
//   DMA state encodings (IDLE/START/READ/WRITE, 2-bit).
//  No sub-module. Contents: FSM, idx counter, data_q, src_hi register, output mux.
// TESTING
//  1 reset_n=0 then 1 -> dma_active=0; CPU read FF46 -> 8'hFF; CPU read 0x0100 -> Di passes.
//  2 WRAM C000+i=i^8'h5A; write 8'hC0 to FF46 -> FE00..FE9F = pattern;
//    dma_active falls after tick 321.
//  3 mid-DMA: CPU read 0x4000 -> cpu_Di=FF, cs_n stays DMA-owned;
//    CPU write 0xC100=8'h33 -> WRAM unchanged.
//  4 at idx=50 write 8'hD0 -> restart; FE00..FE9F = D000..D09F;
//    321 ticks from restart; read FF46 -> D0.
//  5 write 8'hE1 -> READ addresses C100..C19F (echo fold); FE00.. = C100 data.
//  6 reset_n=0 at idx=80 -> next cycle IDLE, cs_n follows CPU, FF46 reads FF;
//    FE00..FE4F already written, rest untouched.

Source files
------------

// File: rtl/oam_dma_controller_pkg.sv
// Shared definitions for the OAM DMA controller: register/OAM constants,
// DMA state encoding and the bus drive bundle used by the output mux.
package oam_dma_controller_pkg;

  localparam logic [15:0] REG_DMA  = 16'hFF46;
  localparam logic [15:0] OAM_BASE = 16'hFE00;
  localparam int          OAM_LEN  = 160;

  typedef enum logic [1:0] {
    DMA_IDLE  = 2'd0,
    DMA_START = 2'd1,
    DMA_READ  = 2'd2,
    DMA_WRITE = 2'd3
  } dma_state_e;

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
    logic        wr_n;
    logic        rd_n;
    logic        cs_n;
  } bus_drive_t;

  localparam bus_drive_t BUS_RELEASED = '{a: 16'h0000, d: 8'h00, wr_n: 1'b1, rd_n: 1'b1, cs_n: 1'b1};

  // Echo RAM (E000-FDFF) mirrors WRAM, so the source page folds down to Cxxx/Dxxx.
  function automatic logic [7:0] echo_fold(input logic [7:0] hi);
    return (hi >= 8'hE0) ? (hi & 8'hDF) : hi;
  endfunction

endpackage

// File: rtl/oam_dma_controller_if.sv
// Game Boy style parallel bus: address, write/read data and active-low strobes.
// The master drives address and strobes; the slave returns read data.
interface oam_dma_controller_if;

  logic [15:0] A;
  logic [7:0]  Do;
  logic [7:0]  Di;
  logic        wr_n;
  logic        rd_n;
  logic        cs_n;

  modport master (output A, Do, wr_n, rd_n, cs_n, input Di);
  modport slave  (input A, Do, wr_n, rd_n, cs_n, output Di);

endinterface

// File: rtl/oam_dma_controller.sv
// Arbitrates the shared bus between the CPU and the OAM DMA engine, which copies
// LENGTH bytes from page src_hi to DEST_BASE one byte per two M-cycles.
module oam_dma_controller
  import oam_dma_controller_pkg::*;
#(
  parameter int          LENGTH    = OAM_LEN,
  parameter logic [15:0] DEST_BASE = OAM_BASE,
  parameter logic [15:0] REG_ADDR  = REG_DMA
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        tick,
  oam_dma_controller_if.slave         cpu,
  oam_dma_controller_if.master        bus,
  output logic                        dma_active
);

  localparam logic [7:0] LAST_IDX = 8'(LENGTH - 1);

  dma_state_e state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] data_q, data_d;
  logic [7:0] src_hi_q, src_hi_d;
  logic       wr_q, wr_d;

  logic       reg_hit;
  logic       reg_wr;
  logic [7:0] src_eff;
  logic [7:0] cpu_di;
  bus_drive_t drv;

  // Register writes fire once per strobe assertion, even if wr_n is held low.
  always_comb begin
    reg_hit = !cpu.cs_n && (cpu.A == REG_ADDR);
    wr_d    = !cpu.wr_n;
    reg_wr  = reg_hit && !cpu.wr_n && !wr_q;
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    data_d   = data_q;
    src_hi_d = src_hi_q;
    if (reg_wr) begin
      state_d  = DMA_START;
      idx_d    = '0;
      src_hi_d = cpu.Do;
    end else if (tick) begin
      case (state_q)
        DMA_IDLE:  state_d = DMA_IDLE;
        DMA_START: state_d = DMA_READ;
        DMA_READ: begin
          data_d  = bus.Di;
          state_d = DMA_WRITE;
        end
        DMA_WRITE: begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = DMA_IDLE;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = DMA_READ;
          end
        end
        default:   state_d = DMA_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= DMA_IDLE;
      idx_q    <= '0;
      data_q   <= '0;
      src_hi_q <= 8'hFF;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      src_hi_q <= src_hi_d;
      wr_q     <= wr_d;
    end
  end

  // While the engine owns the bus the CPU sees 0xFF, except for the DMA register itself.
  always_comb begin
    dma_active = (state_q != DMA_IDLE);
    src_eff    = echo_fold(src_hi_q);
    drv        = BUS_RELEASED;
    case (state_q)
      DMA_IDLE: begin
        drv.a    = cpu.A;
        drv.d    = cpu.Do;
        drv.wr_n = cpu.wr_n | reg_hit;
        drv.rd_n = cpu.rd_n | reg_hit;
        drv.cs_n = cpu.cs_n | reg_hit;
      end
      DMA_START: drv = BUS_RELEASED;
      DMA_READ: begin
        drv.a    = {src_eff, idx_q};
        drv.rd_n = 1'b0;
        drv.cs_n = 1'b0;
      end
      DMA_WRITE: begin
        drv.a    = DEST_BASE + {8'h00, idx_q};
        drv.d    = data_q;
        drv.wr_n = 1'b0;
        drv.cs_n = 1'b0;
      end
      default:   drv = BUS_RELEASED;
    endcase

    if (reg_hit) begin
      cpu_di = src_hi_q;
    end else if (dma_active) begin
      cpu_di = 8'hFF;
    end else begin
      cpu_di = bus.Di;
    end
  end

  assign bus.A    = drv.a;
  assign bus.Do   = drv.d;
  assign bus.wr_n = drv.wr_n;
  assign bus.rd_n = drv.rd_n;
  assign bus.cs_n = drv.cs_n;
  assign cpu.Di   = cpu_di;

endmodule

// File: tb/tb_oam_dma_controller.sv
// Scoreboard bench for oam_dma_controller: a 64 KiB memory model on the bus side,
// a reference memory image, and a monitor that checks every DMA beat and CPU read.
module tb_oam_dma_controller;
  import oam_dma_controller_pkg::*;

  localparam int LEN = OAM_LEN;

  typedef struct packed {
    logic [15:0] rd_addr;
    logic [15:0] wr_addr;
    logic [7:0]  data;
  } dma_exp_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic tick = 1'b0;
  logic dma_active;

  oam_dma_controller_if cpu_if ();
  oam_dma_controller_if bus_if ();

  oam_dma_controller dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .tick       (tick),
    .cpu        (cpu_if),
    .bus        (bus_if),
    .dma_active (dma_active)
  );

  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];
  logic       load_mem = 1'b0;

  dma_exp_t   dma_q[$];
  logic [7:0] rd_q[$];

  int checks = 0;
  int failures = 0;
  int n_wr = 0;
  int active_ticks = 0;
  int tick_snap = 0;
  int tick_phase = 0;

  logic        prev_rd_act = 1'b0;
  logic        prev_wr_act = 1'b0;
  logic        rd_act, wr_act;
  dma_exp_t    mon_e;
  logic        acc_cs_n;
  logic [15:0] acc_A;

  initial forever #5 clock = ~clock;

  // Tick strobe every fourth clock, updated just after the rising edge.
  initial forever begin
    @(posedge clock);
    #1;
    tick_phase = (tick_phase + 1) % 4;
    tick = (tick_phase == 0);
  end

  assign bus_if.Di = mem[bus_if.A];

  always @(posedge clock) begin
    if (load_mem) begin
      for (int i = 0; i < 65536; i++) mem[i] <= ref_mem[i];
    end else if (!bus_if.cs_n && !bus_if.wr_n) begin
      mem[bus_if.A] <= bus_if.Do;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: checks the first clock of every DMA read/write beat and every CPU read.
  always @(negedge clock) begin
    rd_act = dma_active && !bus_if.cs_n && !bus_if.rd_n;
    wr_act = dma_active && !bus_if.cs_n && !bus_if.wr_n;
    if (dma_active && tick) active_ticks++;
    if (rd_act && !prev_rd_act) begin
      if (dma_q.size() == 0) checkOutput("dma_rd_unexpected", 1, 0);
      else                   checkOutput("dma_rd_addr", bus_if.A, dma_q[0].rd_addr);
    end
    if (wr_act && !prev_wr_act) begin
      if (dma_q.size() == 0) begin
        checkOutput("dma_wr_unexpected", 1, 0);
      end else begin
        mon_e = dma_q.pop_front();
        checkOutput("dma_wr_addr", bus_if.A, mon_e.wr_addr);
        checkOutput("dma_wr_data", bus_if.Do, mon_e.data);
      end
      n_wr++;
    end
    prev_rd_act = rd_act;
    prev_wr_act = wr_act;
    if (!cpu_if.cs_n && !cpu_if.rd_n) begin
      if (rd_q.size() == 0) checkOutput("cpu_rd_unexpected", 1, 0);
      else                  checkOutput("cpu_rd_data", cpu_if.Di, rd_q.pop_front());
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  // One CPU access lasting a single clock, followed by an idle clock.
  task automatic applyStimulus(input logic is_wr, input logic [15:0] addr,
                               input logic [7:0] data, input logic [7:0] exp_rd);
    cpu_if.A    = addr;
    cpu_if.Do   = data;
    cpu_if.cs_n = 1'b0;
    cpu_if.wr_n = !is_wr;
    cpu_if.rd_n = is_wr;
    if (!is_wr) rd_q.push_back(exp_rd);
    @(negedge clock);
    acc_cs_n = bus_if.cs_n;
    acc_A    = bus_if.A;
    step();
    cpu_if.cs_n = 1'b1;
    cpu_if.wr_n = 1'b1;
    cpu_if.rd_n = 1'b1;
    step();
  endtask

  function automatic logic [7:0] fold_page(input logic [7:0] src);
    return (src >= 8'hE0) ? src - 8'h20 : src;
  endfunction

  task automatic apply_copy(input logic [7:0] src, input int n);
    for (int i = 0; i < n; i++)
      ref_mem[16'hFE00 + 16'(i)] = ref_mem[{fold_page(src), 8'(i)}];
  endtask

  task automatic start_dma(input logic [7:0] src);
    for (int c = 0; c < 8 && !tick; c++) step();
    applyStimulus(1'b1, 16'hFF46, src, 8'h00);
    dma_q.delete();
    tick_snap = active_ticks;
    for (int i = 0; i < LEN; i++)
      dma_q.push_back('{rd_addr: {fold_page(src), 8'(i)}, wr_addr: 16'hFE00 + 16'(i),
                        data: ref_mem[{fold_page(src), 8'(i)}]});
    checkOutput("dma_active_after_start", dma_active, 1);
  endtask

  task automatic wait_done(input int exp_ticks);
    logic done = 1'b0;
    for (int c = 0; c < 4000 && !done; c++) begin
      @(negedge clock);
      if (!dma_active) done = 1'b1;
    end
    checkOutput("dma_done_in_time", done, 1);
    checkOutput("dma_tick_count", 32'(active_ticks - tick_snap), 32'(exp_ticks));
    step();
    checkOutput("dma_q_drained", dma_q.size(), 0);
  endtask

  task automatic wait_writes(input int base, input int n);
    logic ok = 1'b0;
    for (int c = 0; c < 4000 && !ok; c++) begin
      @(negedge clock);
      if (n_wr - base >= n) ok = 1'b1;
    end
    checkOutput("dma_progress", ok, 1);
    step();
  endtask

  task automatic check_oam(input string name);
    int bad = 0;
    for (int i = 0; i < LEN; i++)
      if (mem[16'hFE00 + 16'(i)] !== ref_mem[16'hFE00 + 16'(i)]) bad++;
    checkOutput(name, bad, 0);
  endtask

  task automatic reload();
    load_mem = 1'b1;
    step();
    load_mem = 1'b0;
  endtask

  initial begin
    logic [7:0]  src;
    logic [15:0] addr;
    logic [7:0]  val;
    int          base;

    cpu_if.A = '0; cpu_if.Do = '0;
    cpu_if.cs_n = 1'b1; cpu_if.wr_n = 1'b1; cpu_if.rd_n = 1'b1;
    for (int i = 0; i < 65536; i++) ref_mem[i] = 8'($urandom);
    for (int i = 0; i < LEN; i++) ref_mem[16'hC000 + 16'(i)] = 8'(i) ^ 8'h5A;
    load_mem = 1'b1;
    repeat (3) step();
    load_mem = 1'b0;
    reset_n = 1'b1;

    $display("[TB] reset and idle pass-through");
    checkOutput("reset_dma_active", dma_active, 0);
    applyStimulus(1'b0, 16'hFF46, 8'h00, 8'hFF);
    checkOutput("reg_rd_hidden_cs_n", acc_cs_n, 1);
    applyStimulus(1'b0, 16'h0100, 8'h00, ref_mem[16'h0100]);
    checkOutput("pass_cs_n", acc_cs_n, 0);
    checkOutput("pass_addr", acc_A, 16'h0100);
    for (int k = 0; k < 4; k++) begin
      addr = 16'h8000 + 16'($urandom_range(0, 16'h1FFF));
      val  = 8'($urandom);
      applyStimulus(1'b1, addr, val, 8'h00);
      ref_mem[addr] = val;
      applyStimulus(1'b0, addr, 8'h00, val);
      addr = 16'($urandom_range(0, 16'h7FFF));
      applyStimulus(1'b0, addr, 8'h00, ref_mem[addr]);
    end

    $display("[TB] full copy from C000 with CPU lockout");
    start_dma(8'hC0);
    repeat (20) step();
    applyStimulus(1'b0, 16'h4000, 8'h00, 8'hFF);
    checkOutput("lock_rd_not_on_bus", acc_A == 16'h4000, 0);
    applyStimulus(1'b1, 16'hC100, 8'h33, 8'h00);
    wait_done(2 * LEN + 1);
    apply_copy(8'hC0, LEN);
    check_oam("oam_after_c0");
    checkOutput("lock_wr_dropped", mem[16'hC100], ref_mem[16'hC100]);

    $display("[TB] restart mid-transfer");
    start_dma(8'hC0);
    base = n_wr;
    wait_writes(base, 50);
    start_dma(8'hD0);
    wait_done(2 * LEN + 1);
    apply_copy(8'hD0, LEN);
    check_oam("oam_after_restart");
    applyStimulus(1'b0, 16'hFF46, 8'h00, 8'hD0);

    $display("[TB] echo source page");
    start_dma(8'hE1);
    wait_done(2 * LEN + 1);
    apply_copy(8'hE1, LEN);
    check_oam("oam_after_echo");

    $display("[TB] random sources");
    for (int k = 0; k < 2; k++) begin
      src = 8'($urandom_range(8'hC0, 8'hFF));
      repeat ($urandom_range(1, 9)) step();
      start_dma(src);
      wait_done(2 * LEN + 1);
      apply_copy(src, LEN);
      check_oam("oam_after_random");
      applyStimulus(1'b0, 16'hFF46, 8'h00, src);
    end

    $display("[TB] reset mid-transfer");
    for (int i = 0; i < LEN; i++)
      ref_mem[16'hFE00 + 16'(i)] = ref_mem[16'hC000 + 16'(i)] ^ 8'hFF;
    reload();
    start_dma(8'hC0);
    base = n_wr;
    wait_writes(base, 80);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    dma_q.delete();
    checkOutput("reset_mid_dma_active", dma_active, 0);
    applyStimulus(1'b0, 16'h0100, 8'h00, ref_mem[16'h0100]);
    checkOutput("reset_pass_cs_n", acc_cs_n, 0);
    checkOutput("reset_pass_addr", acc_A, 16'h0100);
    applyStimulus(1'b0, 16'hFF46, 8'h00, 8'hFF);
    apply_copy(8'hC0, 80);
    check_oam("oam_after_reset");

    repeat (4) step();
    checkOutput("cpu_rd_q_drained", rd_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
